// File: rtl/alu_operand_loader.sv
// Operand assembler and result streamer for the 512-bit signed mul/add ALU.
// Optional `LOADER_ERR_EN adds an err output and aborts commands with op 0/1.
module alu_operand_loader #(
    parameter int WORD_W = 32,
    parameter int OPND_W = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic [1:0]        in_op,
    output logic [1:0]        alu_op,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    input  logic [OPND_W-1:0] alu_c,
    input  logic [OPND_W-1:0] alu_d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
`ifdef LOADER_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int NW    = OPND_W / WORD_W;
    localparam int CNT_W = $clog2(2 * NW);
    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(NW - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(2 * NW - 1);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        EXEC,
        OUT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [OPND_W-1:0] res_c, res_d;
    logic              in_fire, out_fire, op_err;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = (state == LOAD_A) || (state == LOAD_B);
        out_valid = (state == OUT);
        busy      = (state == EXEC) || (state == OUT);
        out_last  = (state == OUT) && (cnt == OUT_LAST);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        op_err    = 1'b0;
`ifdef LOADER_ERR_EN
        op_err    = (state == EXEC) && !alu_op[1];
`endif
        unique case (state)
            LOAD_A: begin
                if (in_fire) begin
                    if (cnt == IN_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = LOAD_B;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (in_fire) begin
                    if (cnt == IN_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = EXEC;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            EXEC: begin
                state_nxt = op_err ? LOAD_A : OUT;
            end
            OUT: begin
                if (out_fire) begin
                    if (cnt == OUT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = LOAD_A;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = LOAD_A;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef LOADER_ERR_EN
    always_comb err = op_err;
`endif

    // Result words: C occupies counts 0..NW-1, D occupies NW..2*NW-1.
    always_comb begin
        out_data = '0;
        if (state == OUT) begin
            for (int unsigned i = 0; i < NW; i++) begin
                if (cnt == CNT_W'(i))
                    out_data = res_c[i*WORD_W +: WORD_W];
                if (cnt == CNT_W'(NW + i))
                    out_data = res_d[i*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
            res_c  <= '0;
            res_d  <= '0;
        end else begin
            if (in_fire) begin
                for (int unsigned i = 0; i < NW; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        if (state == LOAD_A)
                            alu_a[i*WORD_W +: WORD_W] <= in_data;
                        else
                            alu_b[i*WORD_W +: WORD_W] <= in_data;
                    end
                end
                if (state == LOAD_A && cnt == '0)
                    alu_op <= in_op;
            end
            if (state == EXEC) begin
                res_c <= alu_c;
                res_d <= alu_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed self-checking bench for alu_operand_loader with a behavioural signed mul/add ALU.
// Define LOADER_ERR_EN to exercise the err variant.
module tb_alu_operand_loader;

    localparam int WORD_W = 32;
    localparam int OPND_W = 512;
    localparam int NW     = OPND_W / WORD_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_data = '0;
    logic [1:0]        in_op = '0;
    logic [1:0]        alu_op;
    logic [OPND_W-1:0] alu_a, alu_b, alu_c, alu_d;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WORD_W-1:0] out_data;
    logic              out_last;
    logic              busy;
`ifdef LOADER_ERR_EN
    logic              err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_operand_loader #(.WORD_W(WORD_W), .OPND_W(OPND_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_d(alu_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
`ifdef LOADER_ERR_EN
        , .err(err)
`endif
    );

    // Combinational ALU: op 3 = signed add, op 2 = signed multiply, else zero.
    logic signed [2*OPND_W-1:0] sa, sb, full;
    always_comb begin
        sa = {{OPND_W{alu_a[OPND_W-1]}}, alu_a};
        sb = {{OPND_W{alu_b[OPND_W-1]}}, alu_b};
        case (alu_op)
            2'd2:    full = sa * sb;
            2'd3:    full = sa + sb;
            default: full = '0;
        endcase
        alu_c = full[OPND_W-1:0];
        alu_d = full[2*OPND_W-1:OPND_W];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (out_valid && in_ready) begin
                n_fail++;
                $display("FAIL handshake_exclusive: out_valid=%b in_ready=%b required not both 1", out_valid, in_ready);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_word(input logic [31:0] w, input logic [1:0] op);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        in_op    = op;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = $urandom;
        end
    endtask

    // Op is driven only correctly on the first beat; later beats carry ~op.
    task automatic send_cmd(input logic [1:0] op, input logic [511:0] a,
                            input logic [511:0] b, input bit gaps);
        logic [31:0] w;
        for (int i = 0; i < 2 * NW; i++) begin
            if (gaps && (i % 3 == 1)) idle(1 + i % 4);
            if (i < NW) w = a[i*32 +: 32];
            else        w = b[(i-NW)*32 +: 32];
            drive_word(w, (i == 0) ? op : ~op);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(output logic [1023:0] got, output int last_pos,
                           output int n_words, output int first_at);
        int guard;
        guard = 0; got = '0; last_pos = -1; n_words = 0; first_at = -1;
        out_ready = 1'b1;
        while (n_words < 2 * NW && guard < 200) begin
            @(negedge clk);
            guard++;
            if (out_valid) begin
                if (first_at < 0) first_at = guard;
                got[n_words*32 +: 32] = out_data;
                if (out_last) last_pos = n_words;
                n_words++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
            busy !== 1'b0 || alu_op !== 2'd0 || alu_a !== '0 || alu_b !== '0) begin
            n_fail++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_last=%b out_data=%h busy=%b alu_op=%0d required 1 0 0 0 0 0",
                     in_ready, out_valid, out_last, out_data, busy, alu_op);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_small();
        logic [1023:0] exp, got;
        logic [511:0]  b;
        int last_pos, n, first_at;
        b = '1; b[31:0] = 32'hFFFF_FFFD;
        exp = 1024'd2;
        send_cmd(2'd3, 512'd5, b, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_small_exec: busy=%b in_ready=%b out_valid=%b required 1 0 0", busy, in_ready, out_valid);
        end
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        collect(got, last_pos, n, first_at);
        for (int k = 0; k < 2 * NW; k++) begin
            n_checks++;
            if (got[k*32 +: 32] !== exp[k*32 +: 32]) begin
                n_fail++;
                $display("FAIL add_small word%0d: got %h required %h", k, got[k*32 +: 32], exp[k*32 +: 32]);
            end
        end
        n_checks++;
        if (n !== 32 || last_pos !== 31 || first_at !== 1) begin
            n_fail++;
            $display("FAIL add_small_framing: words=%0d last_at=%0d first_at=%0d required 32 31 1", n, last_pos, first_at);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (alu_a !== 512'd5 || alu_b !== b || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_small_ignore_in: alu_a[31:0]=%h alu_b[31:0]=%h busy=%b in_ready=%b required 5 fffffffd 0 1",
                     alu_a[31:0], alu_b[31:0], busy, in_ready);
        end
    endtask

    task automatic test_mul_neg(input bit gaps);
        logic [1023:0] exp, got;
        logic [511:0]  a;
        int last_pos, n, first_at;
        a = '1; a[31:0] = 32'hFFFF_FFFE;
        exp = '1; exp[31:0] = 32'hFFFF_FFFA;
        send_cmd(2'd2, a, 512'd3, gaps);
        collect(got, last_pos, n, first_at);
        for (int k = 0; k < 2 * NW; k++) begin
            n_checks++;
            if (got[k*32 +: 32] !== exp[k*32 +: 32]) begin
                n_fail++;
                $display("FAIL mul_neg(gaps=%0d) word%0d: got %h required %h", gaps, k, got[k*32 +: 32], exp[k*32 +: 32]);
            end
        end
        n_checks++;
        if (n !== 32 || last_pos !== 31) begin
            n_fail++;
            $display("FAIL mul_neg_framing: words=%0d last_at=%0d required 32 31", n, last_pos);
        end
    endtask

    task automatic test_add_max();
        logic [1023:0] exp, got;
        logic [511:0]  a;
        int last_pos, n, first_at;
        a = {1'b0, {511{1'b1}}};
        exp = '0; exp[511] = 1'b1;
        send_cmd(2'd3, a, 512'd1, 1'b0);
        collect(got, last_pos, n, first_at);
        for (int k = 0; k < 2 * NW; k++) begin
            n_checks++;
            if (got[k*32 +: 32] !== exp[k*32 +: 32]) begin
                n_fail++;
                $display("FAIL add_max word%0d: got %h required %h", k, got[k*32 +: 32], exp[k*32 +: 32]);
            end
        end
    endtask

    task automatic test_mul_max();
        logic [1023:0] exp, got;
        logic [511:0]  a;
        int last_pos, n, first_at;
        a = {1'b0, {511{1'b1}}};
        exp = '0; exp[0] = 1'b1; exp[1021:512] = '1;
        send_cmd(2'd2, a, a, 1'b0);
        collect(got, last_pos, n, first_at);
        for (int k = 0; k < 2 * NW; k++) begin
            n_checks++;
            if (got[k*32 +: 32] !== exp[k*32 +: 32]) begin
                n_fail++;
                $display("FAIL mul_max word%0d: got %h required %h", k, got[k*32 +: 32], exp[k*32 +: 32]);
            end
        end
        n_checks++;
        if (first_at !== 1 || last_pos !== 31) begin
            n_fail++;
            $display("FAIL mul_max_latency: first_at=%0d last_at=%0d required 1 31", first_at, last_pos);
        end
    endtask

    task automatic test_backpressure();
        logic [1023:0] exp, got;
        logic [511:0]  a;
        logic [31:0]   held;
        int n, guard, last_pos;
        bit stalled;
        for (int i = 0; i < NW; i++) a[i*32 +: 32] = 32'h1000_0000 + i;
        exp = '0; exp[511:0] = a;
        send_cmd(2'd3, a, 512'd0, 1'b0);
        out_ready = 1'b1; n = 0; guard = 0; stalled = 0; got = '0; last_pos = -1;
        while (n < 2 * NW && guard < 300) begin
            @(negedge clk);
            guard++;
            if (out_valid) begin
                if (n == 5 && !stalled) begin
                    stalled = 1; out_ready = 1'b0; held = out_data;
                    for (int s = 0; s < 10; s++) begin
                        @(negedge clk);
                        n_checks++;
                        if (out_valid !== 1'b1 || out_data !== held || out_last !== 1'b0) begin
                            n_fail++;
                            $display("FAIL backpressure_hold cycle%0d: valid=%b data=%h last=%b required 1 %h 0",
                                     s, out_valid, out_data, out_last, held);
                        end
                    end
                    out_ready = 1'b1;
                end
                got[n*32 +: 32] = out_data;
                if (out_last) last_pos = n;
                n++;
            end
        end
        for (int k = 0; k < 2 * NW; k++) begin
            n_checks++;
            if (got[k*32 +: 32] !== exp[k*32 +: 32]) begin
                n_fail++;
                $display("FAIL backpressure word%0d: got %h required %h", k, got[k*32 +: 32], exp[k*32 +: 32]);
            end
        end
        n_checks++;
        if (n !== 32 || last_pos !== 31) begin
            n_fail++;
            $display("FAIL backpressure_framing: words=%0d last_at=%0d required 32 31", n, last_pos);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_no_dup: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [1023:0] exp, got;
        int last_pos, n, first_at;
        for (int i = 0; i < NW + 7; i++) drive_word(32'hA5A5_0000 + i, (i == 0) ? 2'd2 : 2'd1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== '0 ||
            busy !== 1'b0 || alu_op !== 2'd0 || alu_a !== '0 || alu_b !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_values: in_ready=%b out_valid=%b busy=%b alu_op=%0d alu_a[31:0]=%h alu_b[31:0]=%h required 1 0 0 0 0 0",
                     in_ready, out_valid, busy, alu_op, alu_a[31:0], alu_b[31:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp = 1024'd2;
        send_cmd(2'd3, 512'd1, 512'd1, 1'b0);
        collect(got, last_pos, n, first_at);
        for (int k = 0; k < 2 * NW; k++) begin
            n_checks++;
            if (got[k*32 +: 32] !== exp[k*32 +: 32]) begin
                n_fail++;
                $display("FAIL reset_mid_recover word%0d: got %h required %h", k, got[k*32 +: 32], exp[k*32 +: 32]);
            end
        end
    endtask

    task automatic test_op0();
`ifdef LOADER_ERR_EN
        int n_err, n_ov;
        send_cmd(2'd0, 512'd5, 512'd7, 1'b0);
        n_err = (err === 1'b1) ? 1 : 0;
        n_ov  = (out_valid === 1'b1) ? 1 : 0;
        repeat (8) begin
            @(negedge clk);
            if (err === 1'b1) n_err++;
            if (out_valid === 1'b1) n_ov++;
        end
        n_checks++;
        if (n_err !== 1 || n_ov !== 0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL op0_err: err_cycles=%0d out_valid_cycles=%0d in_ready=%b busy=%b required 1 0 1 0",
                     n_err, n_ov, in_ready, busy);
        end
`else
        logic [1023:0] got;
        int last_pos, n, first_at;
        send_cmd(2'd0, 512'd5, 512'd7, 1'b0);
        collect(got, last_pos, n, first_at);
        n_checks++;
        if (got !== '0 || n !== 32 || last_pos !== 31) begin
            n_fail++;
            $display("FAIL op0_zero: low_word=%h words=%0d last_at=%0d required 00000000 32 31", got[31:0], n, last_pos);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add_small();
        test_mul_neg(1'b0);
        test_add_max();
        test_mul_max();
        test_backpressure();
        test_mul_neg(1'b1);
        test_reset_mid();
        test_op0();
        test_add_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
